// File: rtl/fft_result_streamer.sv
// fft_result_streamer: reads the N complex FFT results out of the working RAM
// (natural or bit-reversed address order) and streams them one bin per
// valid/ready handshake, with a fixed arithmetic right shift on each component.
// Buffering is one output register plus one skid entry. Reads are credit-gated
// so that data returned by the RAM always has a free slot to land in.
module fft_result_streamer #(
    parameter int N          = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = $clog2(N),
    parameter int OUT_SHIFT  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    bitrev_en,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic [2*DATA_WIDTH-1:0] mem_rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0]   out_idx,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    localparam int                    CW       = 2 * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  bitrev_q, bitrev_d;
    logic [ADDR_WIDTH-1:0] rk_q, rk_d;      // next read index
    logic [ADDR_WIDTH-1:0] wk_q, wk_d;      // natural index of the next returned word
    logic                  rd_vld_q;        // RAM data is on mem_rd_data this cycle

    logic                  out_valid_q, out_valid_d;
    logic [CW-1:0]         out_data_q, out_data_d;
    logic [ADDR_WIDTH-1:0] out_idx_q, out_idx_d;
    logic                  out_last_q, out_last_d;

    logic                  skid_valid_q, skid_valid_d;
    logic [CW-1:0]         skid_data_q, skid_data_d;
    logic [ADDR_WIDTH-1:0] skid_idx_q, skid_idx_d;
    logic                  skid_last_q, skid_last_d;

    logic signed [DATA_WIDTH-1:0] rd_re, rd_im;
    logic [CW-1:0]                rd_scaled;
    logic                         rd_last;
    logic                         xfer;
    logic [1:0]                   fill_after;
    logic                         can_issue;

    function automatic logic [ADDR_WIDTH-1:0] bit_reverse(input logic [ADDR_WIDTH-1:0] v);
        logic [ADDR_WIDTH-1:0] r;
        for (int i = 0; i < ADDR_WIDTH; i++) r[i] = v[ADDR_WIDTH-1-i];
        return r;
    endfunction

    // Scaling is a sign-extending floor shift; width is preserved.
    assign rd_re     = mem_rd_data[CW-1:DATA_WIDTH];
    assign rd_im     = mem_rd_data[DATA_WIDTH-1:0];
    assign rd_scaled = {rd_re >>> OUT_SHIFT, rd_im >>> OUT_SHIFT};
    assign rd_last   = (wk_q == LAST_IDX);

    // Occupancy after this edge: held beats minus the one leaving, plus the
    // word landing now. A new read lands one edge later, so it may only be
    // issued while that figure leaves room for it.
    assign xfer       = out_valid_q & out_ready;
    assign fill_after = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_vld_q} - {1'b0, xfer};
    assign can_issue  = (fill_after < 2'd2);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

    // Sequencer: start capture, read issue and end-of-stream detection.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        bitrev_d    = bitrev_q;
        rk_d        = rk_q;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_STREAM;
                    bitrev_d = bitrev_en;
                    rk_d     = '0;
                end
            end
            S_STREAM: begin
                if (can_issue) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = bitrev_q ? bit_reverse(rk_q) : rk_q;
                    rk_d        = rk_q + 1'b1;
                    if (rk_q == LAST_IDX) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (xfer && out_last_q) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output register / skid entry: refill the output slot from the skid
    // first (older beat), then from the RAM; park returning data in the skid
    // while the sink stalls.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_idx_d    = out_idx_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_idx_d   = skid_idx_q;
        skid_last_d  = skid_last_q;
        wk_d         = wk_q;

        if (state_q == S_IDLE) begin
            wk_d = '0;
        end else if (rd_vld_q) begin
            wk_d = wk_q + 1'b1;
        end

        if (!out_valid_q || xfer) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_idx_d    = skid_idx_q;
                out_last_d   = skid_last_q;
                skid_valid_d = rd_vld_q;
                skid_data_d  = rd_scaled;
                skid_idx_d   = wk_q;
                skid_last_d  = rd_last;
            end else if (rd_vld_q) begin
                out_valid_d = 1'b1;
                out_data_d  = rd_scaled;
                out_idx_d   = wk_q;
                out_last_d  = rd_last;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (rd_vld_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = rd_scaled;
            skid_idx_d   = wk_q;
            skid_last_d  = rd_last;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
        if (!rst) begin
            state_q      <= S_IDLE;
            bitrev_q     <= 1'b0;
            rk_q         <= '0;
            wk_q         <= '0;
            rd_vld_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            // NOTE: data registers are reset too because out_data/out_idx must read 0 after reset.
            out_data_q   <= '0;
            out_idx_q    <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_idx_q   <= '0;
            skid_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitrev_q     <= bitrev_d;
            rk_q         <= rk_d;
            wk_q         <= wk_d;
            rd_vld_q     <= mem_rd_en;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_idx_q    <= out_idx_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_idx_q   <= skid_idx_d;
            skid_last_q  <= skid_last_d;
        end
    end

endmodule

// File: tb/tb_fft_result_streamer.sv
// Testbench for fft_result_streamer: two instances (OUT_SHIFT 0 and 4) share
// control inputs and have their own RAM models. Expected beats and read
// addresses are pushed at start; negedge monitors pop and compare.
module tb_fft_result_streamer;

    localparam int N  = 16;
    localparam int DW = 16;
    localparam int AW = 4;

    typedef struct packed {
        logic [2*DW-1:0] data;
        logic [AW-1:0]   idx;
        logic            last;
    } beat_t;

    logic clk = 1'b0;
    logic rst, start, bitrev_en, out_ready;

    logic          rd_en0, rd_en4, ov0, ov4, ol0, ol4, busy0, busy4, done0, done4;
    logic [AW-1:0] rd_addr0, rd_addr4, oi0, oi4;
    logic [31:0]   rd_data0, rd_data4, od0, od4;

    logic [31:0] ram0 [N];
    logic [31:0] ram4 [N];

    beat_t exp0_q[$];
    beat_t exp4_q[$];
    int    addr0_q[$];

    int checks = 0;
    int errors = 0;
    int n_xfer0 = 0;
    int n_iss0 = 0;
    bit stall0 = 1'b0;
    logic [37:0] held0 = '0;

    always #5 clk = ~clk;

    fft_result_streamer #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .bitrev_en(bitrev_en),
        .mem_rd_en(rd_en0), .mem_rd_addr(rd_addr0), .mem_rd_data(rd_data0),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_idx(oi0),
        .out_last(ol0), .busy(busy0), .done(done0)
    );

    fft_result_streamer #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_SHIFT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .bitrev_en(bitrev_en),
        .mem_rd_en(rd_en4), .mem_rd_addr(rd_addr4), .mem_rd_data(rd_data4),
        .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .out_idx(oi4),
        .out_last(ol4), .busy(busy4), .done(done4)
    );

    // Synchronous-read RAMs: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en0) rd_data0 <= ram0[rd_addr0];
        if (rd_en4) rd_data4 <= ram4[rd_addr4];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic int bitrev(input int v);
        int r = 0;
        int x = v;
        for (int i = 0; i < AW; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    // floor(v / 2^s) on a signed 16-bit value
    function automatic logic [15:0] scale(input logic [15:0] v, input int s);
        int x, d, q;
        x = int'($signed(v));
        d = 1 << s;
        if (x >= 0) q = x / d;
        else        q = -((-x + d - 1) / d);
        return q[15:0];
    endfunction

    // Monitor for the unscaled instance: read order, credit bound, beats, stall hold.
    always @(negedge clk) begin
        beat_t a, e;
        int    occ;
        if (rd_en0) begin
            check("rd_in_idle_or_done", {busy0, done0}, 2'b10);
            n_iss0++;
            occ = n_iss0 - n_xfer0 - ((ov0 && out_ready) ? 1 : 0);
            checks++;
            if (occ > 2) begin
                errors++;
                $display("FAIL outstanding: got %0d reads+entries, required at most 2", occ);
            end
            if (addr0_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected: got read of %0d, required no read", rd_addr0);
            end else begin
                check("rd_addr", rd_addr0, addr0_q.pop_front());
            end
        end
        if (rst && ov0 && out_ready) begin
            a = '{data: od0, idx: oi0, last: ol0};
            if (exp0_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL beat0_unexpected: got %0h, required no beat", a);
            end else begin
                e = exp0_q.pop_front();
                check("beat0", a, e);
            end
            n_xfer0++;
        end
        if (stall0) check("stall_hold", {ov0, od0, oi0, ol0}, held0);
        stall0 = rst && ov0 && !out_ready;
        held0  = {ov0, od0, oi0, ol0};
        if (!busy0) begin
            n_iss0  = 0;
            n_xfer0 = 0;
        end
    end

    // Monitor for the scaled instance: beats only.
    always @(negedge clk) begin
        beat_t a, e;
        if (rst && ov4 && out_ready) begin
            a = '{data: od4, idx: oi4, last: ol4};
            if (exp4_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL beat4_unexpected: got %0h, required no beat", a);
            end else begin
                e = exp4_q.pop_front();
                check("beat4", a, e);
            end
        end
    end

    task automatic fill_natural();
        for (int a = 0; a < N; a++) begin
            ram0[a] = {16'(a), 16'(-a)};
            ram4[a] = {16'(a * 300), 16'(-a * 300)};
        end
        ram4[0] = {16'hFFFF, 16'h7FFF};
        ram4[1] = {16'hFFEF, 16'h0010};
        ram4[2] = {16'hFFF0, 16'h8000};
    endtask

    task automatic fill_random();
        for (int a = 0; a < N; a++) begin
            ram0[a] = $urandom;
            ram4[a] = $urandom;
        end
    endtask

    // Pulse start (sampled at the next edge, E0) and push the expected stream.
    task automatic do_start(input bit br);
        int a;
        start     = 1'b1;
        bitrev_en = br;
        for (int k = 0; k < N; k++) begin
            a = br ? bitrev(k) : k;
            addr0_q.push_back(a);
            exp0_q.push_back('{data: ram0[a], idx: AW'(k), last: (k == N - 1)});
            exp4_q.push_back('{data: {scale(ram4[a][31:16], 4), scale(ram4[a][15:0], 4)},
                               idx: AW'(k), last: (k == N - 1)});
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_outs0"}, {rd_en0, rd_addr0, ov0, od0, oi0, ol0, busy0, done0}, 64'd0);
        check({tag, "_outs4"}, {rd_en4, rd_addr4, ov4, od4, oi4, ol4, busy4, done4}, 64'd0);
    endtask

    // mode 0: ready=1; 1: alternate + 5-cycle stall at k=6; 2: random ready;
    // 3: ready=1 with a stray start at k=5; 4: ready=1, reset at k=9.
    task automatic run_stream(input bit br, input int mode);
        int cyc = 0;
        int stall_n = 0;
        bit got_done = 1'b0;
        bit mid_sent = 1'b0;
        do_start(br);
        while (!got_done && cyc < 300) begin
            case (mode)
                1: begin
                    if (n_xfer0 == 6 && stall_n < 5) begin
                        out_ready = 1'b0;
                        stall_n++;
                    end else begin
                        out_ready = (cyc % 2 == 0);
                    end
                end
                2:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
            if (mode == 3 && n_xfer0 == 5 && !mid_sent) begin
                start     = 1'b1;
                bitrev_en = ~br;
                mid_sent  = 1'b1;
            end
            if (mode == 4 && n_xfer0 == 9) begin
                out_ready = 1'b0;
                rst       = 1'b0;
                @(posedge clk); #1;
                rst = 1'b1;
                @(negedge clk);
                check_reset_outputs("midreset");
                exp0_q.delete();
                exp4_q.delete();
                addr0_q.delete();
                @(posedge clk); #1;
                return;
            end
            @(negedge clk);
            if (cyc <= 1) check("latency_low", ov0, 1'b0);
            if (cyc == 2) check("latency_high", {ov0, ov4}, 2'b11);
            if (done0) begin
                got_done = 1'b1;
                if (mode == 0 || mode == 3) check("done_cycle", cyc, N + 2);
                check("done4_with_done0", done4, 1'b1);
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        if (!got_done) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done in %0d cycles, required done", cyc);
        end
        @(negedge clk);
        check("post_done_idle", {busy0, done0, busy4, done4}, 4'b0000);
        check("beats_left", exp0_q.size() + exp4_q.size() + addr0_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        bitrev_en = 1'b0;
        out_ready = 1'b0;
        fill_natural();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        run_stream(1'b0, 0);   // natural order
        run_stream(1'b1, 0);   // bit-reversed
        run_stream(1'b0, 1);   // backpressure with long stall
        run_stream(1'b0, 3);   // start while busy is ignored
        run_stream(1'b1, 4);   // reset mid-stream
        run_stream(1'b0, 0);   // restart after reset
        fill_random();
        run_stream(1'b1, 1);
        for (int i = 0; i < 4; i++) run_stream(1'($urandom_range(0, 1)), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fft_result_streamer.md
# fft_result_streamer

Output-side unloader for the shared-butterfly DIT FFT core. After the core finishes, this block reads the N complex results out of the FFT working RAM and streams them one bin per handshake on a valid/ready interface. It is the counterpart of the serial sample loader that feeds `x_in_ext`. It supports optional bit-reversed address reordering and a fixed arithmetic output scaling.

## Interface
- `N`, 16: FFT length; power of two, ≥ 4.
- `DATA_WIDTH`, 16: width of each real/imag component.
- `ADDR_WIDTH`, $clog2(N): RAM address and bin-index width.
- `OUT_SHIFT`, 0: arithmetic right shift applied to each component; range 0..ADDR_WIDTH.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset (sampled on `clk` rising edge; 0 = reset).
- `start`  in  1  one-cycle pulse, normally the core's `done`; ignored while `busy`.
- `bitrev_en`  in  1  sampled with `start`; 1 = read RAM in bit-reversed address order.
- `mem_rd_en`  out  1  RAM read strobe.
- `mem_rd_addr`  out  ADDR_WIDTH  RAM read address.
- `mem_rd_data`  in  2*DATA_WIDTH  {re, im}, valid exactly 1 cycle after the `mem_rd_en` edge.
- `out_valid`  out  1  `out_data` holds a bin.
- `out_ready`  in  1  sink accepts; a transfer occurs on an edge where `out_valid & out_ready`.
- `out_data`  out  2*DATA_WIDTH  {re, im} after scaling; signed two's complement.
- `out_idx`  out  ADDR_WIDTH  natural bin index k of `out_data`.
- `out_last`  out  1  high with the beat where `out_idx` = N-1.
- `busy`  out  1  high from the edge that samples `start` until `done`.
- `done`  out  1  one-cycle pulse after the last transfer.

## Operation
- States:
  - IDLE: wait for `start`.
  - STREAM: issue reads and present beats.
  - FLUSH: wait for outstanding beats to transfer.
  - DONE: one cycle asserting `done`, then back to IDLE.
- IDLE→STREAM on `start`=1. This edge latches `bitrev_en`, clears the read counter `rk` and the output counter, and sets `busy`.
- Read address:
  - `bitrev_en`=1: `mem_rd_addr` = bit-reverse of `rk` over ADDR_WIDTH bits.
  - `bitrev_en`=0: `mem_rd_addr` = `rk`.
  - `rk` increments on each issued read.
- Buffering: one output register plus one skid entry.
  - A read is issued only if (outstanding reads + occupied entries) < 2 after accounting for a transfer on the same edge.
  - Net effect: no beat is ever dropped or duplicated.
  - With `out_ready` held at 1, throughput is 1 beat/cycle.
- STREAM→FLUSH after the read with `rk` = N-1 is issued. FLUSH→DONE on the edge that transfers `out_last`.
- `out_data`, `out_idx` and `out_last` hold stable while `out_valid`=1 and `out_ready`=0.
- `out_idx` counts 0..N-1 in transfer order, regardless of `bitrev_en`.
- Scaling: each component is arithmetic-right-shifted by `OUT_SHIFT` (sign-extended floor; no rounding, no saturation). Width is unchanged.
- `start` while `busy`=1 is ignored.
- `rst`=0 at any cycle, including mid-stream: state returns to IDLE, the skid entry is discarded, any outstanding read is abandoned.
- Reset values: all outputs 0 (`mem_rd_en`, `mem_rd_addr`, `out_valid`, `out_data`, `out_idx`, `out_last`, `busy`, `done`).

## Timing
- Let E0 be the edge where `start` is sampled.
  - `mem_rd_en`=1 with address for k=0 during the cycle after E0.
  - Data is returned after E1.
  - `out_valid`=1 after E2, so first-beat latency is 2 cycles.
- With `out_ready`=1 throughout:
  - Beat k is valid after E(k+2) and transfers at E(k+3).
  - `out_last` is seen after E(N+1).
  - `done`=1 for exactly the cycle after E(N+2).
  - `busy` falls with `done` deasserting.
- Backpressure:
  - At most 2 reads are ever outstanding or buffered.
  - When `out_ready` rises after a stall, the next beat appears on the following cycle.
- `mem_rd_en` is never asserted in IDLE or DONE.

## Test plan
- **Natural order, ready=1:** RAM[a] = {a, -a}, N=16, OUT_SHIFT=0, `start` at E0.
  - `out_valid` rises after E2.
  - Beats k=0..15 carry {k, -k} on consecutive cycles.
  - `out_last` on k=15; `done` pulse after E18.
- **Bit-reversed:** same RAM, `bitrev_en`=1.
  - `mem_rd_addr` sequence is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
  - `out_idx` is 0..15 and the re field equals bitrev(`out_idx`).
- **Backpressure:** `out_ready` alternates 1/0, then is held at 0 for 5 cycles at k=6.
  - `out_data` is stable during the stall.
  - Each k=0..15 transfers exactly once, in order.
  - No read is issued while both buffer entries are full.
- **Scaling:** OUT_SHIFT=4, RAM words {-1, 0x7FFF}, {-17, 0x0010}, {-16, 0x8000}.
  - Outputs are {-1, 0x07FF}, {-2, 0x0001}, {-1, 0xF800}.
- **Control:**
  - A `start` pulse at k=5 while busy is ignored; the stream is unchanged.
  - `rst`=0 at k=9: all outputs are 0 on the next cycle.
  - A new `start` after reset restarts at k=0 with 2-cycle latency.
